// File: rtl/jtag_dma_engine_if.sv
// Single-beat bus master port of the JTAG DMA engine: request/address/data
// from the engine, ack/err/rdata back from the bus.
interface jtag_dma_engine_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/jtag_dma_engine.sv
// Burst DMA between the engine side of a ping-pong buffer and a single-beat
// bus; one word per beat, fixed byte lanes, incrementing word address.
module jtag_dma_engine #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               dma_address,
  input  logic [3:0]                dma_byte_enable,
  input  logic [7:0]                burst_size,
  input  logic                      dma_data_ready,
  input  logic                      dma_readReady,
  output logic                      switch_ready,
  output logic [8:0]                dma_pp_address,
  output logic                      dma_pp_writeEnable,
  output logic [31:0]               dma_pp_dataIn,
  input  logic [31:0]               dma_pp_dataOut,
  jtag_dma_engine_if.master         bus,
  output logic                      busy,
  output logic                      done,
  output logic                      dma_error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_W_FETCH = 3'd1;
  localparam logic [2:0] S_W_BUS   = 3'd2;
  localparam logic [2:0] S_R_BUS   = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [7:0]  burst_q;
  logic [7:0]  idx_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [15:0] tmo_cnt;
  logic        err_q;

  logic in_bus;
  logic beat_ok;
  logic first_bus_cycle;

  assign in_bus          = (state == S_W_BUS) || (state == S_R_BUS);
  assign beat_ok         = in_bus && bus.bus_ack && !bus.bus_err;
  assign first_bus_cycle = (tmo_cnt == 16'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      burst_q <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dma_data_ready || dma_readReady) begin
            addr_q  <= dma_address;
            be_q    <= dma_byte_enable;
            burst_q <= burst_size;
            idx_q   <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
            write_q <= dma_data_ready;
            state   <= dma_data_ready ? S_W_FETCH : S_R_BUS;
          end
        end
        S_W_FETCH: begin
          tmo_cnt <= '0;
          state   <= S_W_BUS;
        end
        S_W_BUS, S_R_BUS: begin
          // Buffer word arrives in the first W_BUS cycle; hold it for the rest of the beat.
          if ((state == S_W_BUS) && first_bus_cycle)
            wdata_q <= dma_pp_dataOut;
          if (bus.bus_ack) begin
            if (bus.bus_err) begin
              err_q <= 1'b1;
              state <= S_FINISH;
            end else if (idx_q == burst_q) begin
              state <= S_FINISH;
            end else begin
              idx_q  <= idx_q + 8'd1;
              addr_q <= addr_q + 32'd4;
              state  <= S_NEXT;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= S_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_NEXT: begin
          tmo_cnt <= '0;
          state   <= write_q ? S_W_FETCH : S_R_BUS;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign switch_ready = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_FINISH);
  assign dma_error    = err_q;

  assign bus.bus_req   = in_bus;
  assign bus.bus_we    = (state == S_W_BUS);
  assign bus.bus_addr  = in_bus ? addr_q : 32'd0;
  assign bus.bus_be    = in_bus ? be_q : 4'd0;
  assign bus.bus_wdata = (state != S_W_BUS) ? 32'd0 :
                         (first_bus_cycle ? dma_pp_dataOut : wdata_q);

  // Read beats land in the buffer in the same cycle the bus acknowledges.
  assign dma_pp_writeEnable = (state == S_R_BUS) && beat_ok;
  assign dma_pp_address     = ((state == S_W_FETCH) || dma_pp_writeEnable) ? {1'b0, idx_q} : 9'd0;
  assign dma_pp_dataIn      = dma_pp_writeEnable ? bus.bus_rdata : 32'd0;

endmodule

// File: tb/tb_jtag_dma_engine.sv
// Scoreboard bench for jtag_dma_engine: directed bursts, bus slave model and
// ping-pong buffer model; a negedge monitor pops expected events.
module tb_jtag_dma_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dma_address;
  logic [3:0]  dma_byte_enable;
  logic [7:0]  burst_size;
  logic        dma_data_ready;
  logic        dma_readReady;
  logic        switch_ready;
  logic [8:0]  dma_pp_address;
  logic        dma_pp_writeEnable;
  logic [31:0] dma_pp_dataIn;
  logic [31:0] dma_pp_dataOut;
  logic        busy;
  logic        done;
  logic        dma_error;

  always #5 clock = ~clock;

  jtag_dma_engine_if bif();

  jtag_dma_engine #(.TIMEOUT_CYCLES(8)) dut (
    .clock              (clock),
    .reset              (reset),
    .dma_address        (dma_address),
    .dma_byte_enable    (dma_byte_enable),
    .burst_size         (burst_size),
    .dma_data_ready     (dma_data_ready),
    .dma_readReady      (dma_readReady),
    .switch_ready       (switch_ready),
    .dma_pp_address     (dma_pp_address),
    .dma_pp_writeEnable (dma_pp_writeEnable),
    .dma_pp_dataIn      (dma_pp_dataIn),
    .dma_pp_dataOut     (dma_pp_dataOut),
    .bus                (bif),
    .busy               (busy),
    .done               (done),
    .dma_error          (dma_error)
  );

  // Buffer model: src feeds write bursts, dst collects read bursts.
  logic [31:0] src [0:511];
  logic [31:0] dst [0:511];
  always @(posedge clock) begin
    if (dma_pp_writeEnable) dst[dma_pp_address] <= dma_pp_dataIn;
    dma_pp_dataOut <= src[dma_pp_address];
  end

  // Bus slave model.
  int          slv_delay    = 1;
  bit          slv_never    = 1'b0;
  int          slv_err_beat = -1;
  int          slv_beat     = 0;
  int          slv_cnt      = 0;
  logic [31:0] rd_tab [0:7];

  always @(posedge clock) begin
    #1;
    if (switch_ready) slv_beat = 0;
    bif.bus_ack = 1'b0;
    bif.bus_err = 1'b0;
    if (reset) begin
      slv_cnt = 0;
    end else if (bif.bus_req && !slv_never) begin
      if (slv_cnt >= slv_delay) begin
        bif.bus_ack   = 1'b1;
        bif.bus_err   = (slv_beat == slv_err_beat);
        bif.bus_rdata = rd_tab[slv_beat];
        slv_beat++;
        slv_cnt = 0;
      end else begin
        slv_cnt++;
      end
    end else begin
      slv_cnt = 0;
    end
  end

  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        err;
  } exp_t;

  localparam int K_BUS  = 0;
  localparam int K_PPW  = 1;
  localparam int K_DONE = 2;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    exp_t e;
    e.kind = K_BUS; e.we = we; e.addr = a; e.be = be; e.data = d; e.err = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic exp_ppw(input logic [8:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = K_PPW; e.we = 1'b1; e.addr = 32'(a); e.be = 4'd0; e.data = d; e.err = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic exp_done(input logic err);
    exp_t e;
    e.kind = K_DONE; e.we = 1'b0; e.addr = 32'd0; e.be = 4'd0; e.data = 32'd0; e.err = err;
    sbq.push_back(e);
  endtask

  // Monitor: every observable DUT event consumes one scoreboard entry.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset) begin
      if (bif.bus_req && bif.bus_ack) begin
        if (sbq.size() == 0) chk("unexpected_bus_beat", 64'(bif.bus_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          e = sbq.pop_front();
          chk("bus_kind", 64'(K_BUS), 64'(e.kind));
          chk("bus_we",   64'(bif.bus_we),   64'(e.we));
          chk("bus_addr", 64'(bif.bus_addr), 64'(e.addr));
          chk("bus_be",   64'(bif.bus_be),   64'(e.be));
          if (e.we) chk("bus_wdata", 64'(bif.bus_wdata), 64'(e.data));
        end
      end
      if (dma_pp_writeEnable) begin
        if (sbq.size() == 0) chk("unexpected_buf_write", 64'(dma_pp_address), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          e = sbq.pop_front();
          chk("ppw_kind", 64'(K_PPW), 64'(e.kind));
          chk("ppw_addr", 64'(dma_pp_address), 64'(e.addr));
          chk("ppw_data", 64'(dma_pp_dataIn),  64'(e.data));
        end
      end
      if (done) begin
        if (sbq.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
        else begin
          e = sbq.pop_front();
          chk("done_kind",  64'(K_DONE), 64'(e.kind));
          chk("done_error", 64'(dma_error), 64'(e.err));
        end
      end
    end
  end

  task automatic launch(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [3:0] be, input logic [7:0] bs);
    @(negedge clock);
    dma_address     = a;
    dma_byte_enable = be;
    burst_size      = bs;
    dma_data_ready  = wr;
    dma_readReady   = rd;
    @(negedge clock);
    dma_data_ready  = 1'b0;
    dma_readReady   = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(switch_ready && sbq.size() == 0) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    chk(nm, 64'(sbq.size()), 64'(0));
    sbq.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    dma_address = '0; dma_byte_enable = '0; burst_size = '0;
    dma_data_ready = 1'b0; dma_readReady = 1'b0;
    for (int i = 0; i < 512; i++) src[i] = 32'd0;
    for (int i = 0; i < 8; i++) rd_tab[i] = 32'd0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_switch_ready", 64'(switch_ready), 64'(1));
    chk("rst_busy",         64'(busy),         64'(0));
    chk("rst_bus_req",      64'(bif.bus_req),  64'(0));
    chk("rst_done",         64'(done),         64'(0));
    chk("rst_dma_error",    64'(dma_error),    64'(0));
    chk("rst_pp_we",        64'(dma_pp_writeEnable), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    chk("idle_switch_ready", 64'(switch_ready), 64'(1));

    // Four-beat write burst
    src[0] = 32'hAAAA_0001; src[1] = 32'hBBBB_0002; src[2] = 32'hCCCC_0003; src[3] = 32'hDDDD_0004;
    slv_delay = 1;
    exp_bus(1'b1, 32'h1000_0000, 4'hF, 32'hAAAA_0001);
    exp_bus(1'b1, 32'h1000_0004, 4'hF, 32'hBBBB_0002);
    exp_bus(1'b1, 32'h1000_0008, 4'hF, 32'hCCCC_0003);
    exp_bus(1'b1, 32'h1000_000C, 4'hF, 32'hDDDD_0004);
    exp_done(1'b0);
    launch(1'b1, 1'b0, 32'h1000_0000, 4'hF, 8'd3);
    n = 1;
    while (!bif.bus_req && n < 20) begin @(negedge clock); n++; end
    chk("wr_req_latency", 64'(n), 64'(2));
    wait_idle("wr4_drain");
    chk("wr4_error", 64'(dma_error), 64'(0));

    // Single-beat read at the top of the address space, then a wrapping pair
    rd_tab[0] = 32'hDEAD_BEEF; rd_tab[1] = 32'h1234_5678;
    exp_bus(1'b0, 32'hFFFF_FFFC, 4'hF, 32'd0);
    exp_ppw(9'd0, 32'hDEAD_BEEF);
    exp_done(1'b0);
    launch(1'b0, 1'b1, 32'hFFFF_FFFC, 4'hF, 8'd0);
    chk("rd_req_latency", 64'(bif.bus_req), 64'(1));
    wait_idle("rd1_drain");
    chk("rd1_buf0", 64'(dst[0]), 64'(32'hDEAD_BEEF));

    rd_tab[0] = 32'hCAFE_0000;
    exp_bus(1'b0, 32'hFFFF_FFFC, 4'h3, 32'd0);
    exp_ppw(9'd0, 32'hCAFE_0000);
    exp_bus(1'b0, 32'h0000_0000, 4'h3, 32'd0);
    exp_ppw(9'd1, 32'h1234_5678);
    exp_done(1'b0);
    launch(1'b0, 1'b1, 32'hFFFF_FFFC, 4'h3, 8'd1);
    wait_idle("rd2_drain");
    chk("rd2_buf1", 64'(dst[1]), 64'(32'h1234_5678));

    // Simultaneous launch pulses: write wins
    src[0] = 32'h55AA_55AA;
    exp_bus(1'b1, 32'h0000_2000, 4'hF, 32'h55AA_55AA);
    exp_done(1'b0);
    launch(1'b1, 1'b1, 32'h0000_2000, 4'hF, 8'd0);
    wait_idle("both_drain");

    // Bus error on beat 2 of a five-beat read
    for (int i = 0; i < 5; i++) rd_tab[i] = 32'h0000_0100 + 32'(i);
    slv_err_beat = 2;
    exp_bus(1'b0, 32'h0000_3000, 4'hF, 32'd0);
    exp_ppw(9'd0, 32'h0000_0100);
    exp_bus(1'b0, 32'h0000_3004, 4'hF, 32'd0);
    exp_ppw(9'd1, 32'h0000_0101);
    exp_bus(1'b0, 32'h0000_3008, 4'hF, 32'd0);
    exp_done(1'b1);
    launch(1'b0, 1'b1, 32'h0000_3000, 4'hF, 8'd4);
    wait_idle("err_drain");
    chk("err_sticky",       64'(dma_error),    64'(1));
    chk("err_switch_ready", 64'(switch_ready), 64'(1));
    slv_err_beat = -1;
    src[0] = 32'h0BAD_F00D;
    exp_bus(1'b1, 32'h0000_3100, 4'hF, 32'h0BAD_F00D);
    exp_done(1'b0);
    launch(1'b1, 1'b0, 32'h0000_3100, 4'hF, 8'd0);
    chk("err_cleared_on_launch", 64'(dma_error), 64'(0));
    wait_idle("err_clear_drain");

    // Timeout: slave never acknowledges
    slv_never = 1'b1;
    exp_done(1'b1);
    launch(1'b0, 1'b1, 32'h0000_4000, 4'hF, 8'd0);
    n = 0;
    while (bif.bus_req && n < 50) begin @(negedge clock); n++; end
    chk("tmo_req_cycles", 64'(n), 64'(8));
    wait_idle("tmo_drain");
    chk("tmo_error",        64'(dma_error),    64'(1));
    chk("tmo_switch_ready", 64'(switch_ready), 64'(1));
    slv_never = 1'b0;

    // Reset during beat 1 of a four-beat write
    src[0] = 32'h0000_0A01; src[1] = 32'h0000_0A02; src[2] = 32'h0000_0A03; src[3] = 32'h0000_0A04;
    slv_delay = 2;
    exp_bus(1'b1, 32'h0000_5000, 4'hF, 32'h0000_0A01);
    launch(1'b1, 1'b0, 32'h0000_5000, 4'hF, 8'd3);
    n = 0;
    while (!(bif.bus_req && slv_beat == 1) && n < 100) begin @(negedge clock); n++; end
    chk("rst_mid_reached_beat1", 64'(bif.bus_req), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_req_drop", 64'(bif.bus_req), 64'(0));
    chk("rst_mid_no_done",  64'(done),        64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("rst_mid_no_done_after", 64'(done), 64'(0));
    end
    chk("rst_mid_switch_ready", 64'(switch_ready), 64'(1));
    chk("rst_mid_queue",        64'(sbq.size()),   64'(0));
    sbq.delete();

    slv_delay = 0;
    src[0] = 32'h6000_0001; src[1] = 32'h6000_0002;
    exp_bus(1'b1, 32'h0000_6000, 4'h5, 32'h6000_0001);
    exp_bus(1'b1, 32'h0000_6004, 4'h5, 32'h6000_0002);
    exp_done(1'b0);
    launch(1'b1, 1'b0, 32'h0000_6000, 4'h5, 8'd1);
    wait_idle("post_rst_drain");
    chk("post_rst_error", 64'(dma_error), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
